// File: rtl/qqvga_scanout.sv
// rtl/qqvga_scanout.sv - 160x120x1 framebuffer scanned out as 640x480@60 VGA with 4x4 pixel scaling
module qqvga_scanout #(
  parameter int ADDR_WIDTH = 15,
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int COLOR_BITS = 4,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                  clk_25,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  pixel,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic [COLOR_BITS-1:0] vga_r,
  output logic [COLOR_BITS-1:0] vga_g,
  output logic [COLOR_BITS-1:0] vga_b,
  output logic                  blank,
  output logic                  frame_start
);

  // Screen geometry: each stored pixel covers a 4x4 block of screen pixels.
  localparam int H_VIS   = 4 * H_RES;
  localparam int H_SS    = H_VIS + H_FP;
  localparam int H_SE    = H_SS + H_SYNC;
  localparam int H_TOT   = H_SE + H_BP;
  localparam int V_VIS   = 4 * V_RES;
  localparam int V_SS    = V_VIS + V_FP;
  localparam int V_SE    = V_SS + V_SYNC;
  localparam int V_TOT   = V_SE + V_BP;
  localparam int FB_SIZE = H_RES * V_RES;
  localparam int HW      = $clog2(H_TOT);
  localparam int VW      = $clog2(V_TOT);

  logic [HW-1:0]         hcnt;
  logic [VW-1:0]         vcnt;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  h_wrap;
  logic                  v_wrap;
  logic                  visible;
  logic                  hs_act;
  logic                  vs_act;
  logic                  first_px;

  logic                  mem [0:(1<<ADDR_WIDTH)-1];
  logic                  rd_data;

  logic                  s1_hsync;
  logic                  s1_vsync;
  logic                  s1_blank;
  logic                  s1_first;
  logic [COLOR_BITS-1:0] color;

  assign h_wrap   = (hcnt == HW'(H_TOT - 1));
  assign v_wrap   = (vcnt == VW'(V_TOT - 1));
  assign visible  = (hcnt < HW'(H_VIS)) && (vcnt < VW'(V_VIS));
  assign hs_act   = (hcnt >= HW'(H_SS)) && (hcnt < HW'(H_SE));
  assign vs_act   = (vcnt >= VW'(V_SS)) && (vcnt < VW'(V_SE));
  assign first_px = (hcnt == '0) && (vcnt == '0);

  // Address only tracks the beam while visible; in blanking it parks on its last value.
  assign rd_addr  = visible ? (row_base + ADDR_WIDTH'(hcnt[HW-1:2])) : addr_hold;

  // Stage 0: horizontal and vertical beam counters.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      vcnt <= v_wrap ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Stage 0: row base address, stepped by one stored line after every 4th visible screen line.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      row_base <= '0;
    end else if (h_wrap) begin
      if (v_wrap) begin
        row_base <= '0;
      end else if ((vcnt[1:0] == 2'b11) && (vcnt < VW'(V_VIS))) begin
        row_base <= row_base + ADDR_WIDTH'(H_RES);
      end
    end
  end

  // Stage 0: remember the last address driven so blanking keeps it stable.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      addr_hold <= '0;
    end else begin
      addr_hold <= rd_addr;
    end
  end

  // Framebuffer: read-first RAM, out-of-range writes dropped, contents never reset.
  always_ff @(posedge clk_25) begin
    if (we && (int'(write_addr) < FB_SIZE)) begin
      mem[write_addr] <= pixel;
    end
    rd_data <= mem[rd_addr];
  end

  // Stage 1: delay timing flags to line up with the registered RAM data.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      s1_hsync <= 1'b1;
      s1_vsync <= 1'b1;
      s1_blank <= 1'b1;
      s1_first <= 1'b0;
    end else begin
      s1_hsync <= ~hs_act;
      s1_vsync <= ~vs_act;
      s1_blank <= ~visible;
      s1_first <= first_px;
    end
  end

  assign color = {COLOR_BITS{rd_data & ~s1_blank}};

  // Stage 2: registered outputs, colour forced dark during blanking.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= s1_hsync;
      vga_vsync   <= s1_vsync;
      vga_r       <= color;
      vga_g       <= color;
      vga_b       <= color;
      blank       <= s1_blank;
      frame_start <= s1_first;
    end
  end

endmodule

// File: tb/tb_qqvga_scanout.sv
// tb/tb_qqvga_scanout.sv - directed self-checking bench for qqvga_scanout on a reduced screen geometry
module tb_qqvga_scanout;

  // Reduced geometry: 4x3 stored pixels, 16x12 visible, H 16+4+8+4=32, V 12+2+2+3=19.
  localparam int HV    = 16;
  localparam int HS0   = 20;
  localparam int HS1   = 28;
  localparam int HT    = 32;
  localparam int VV    = 12;
  localparam int VS0   = 14;
  localparam int VS1   = 16;
  localparam int VT    = 19;
  localparam int FRAME = HT * VT;
  localparam int FBN   = 12;

  logic       clk_25 = 1'b0;
  logic       reset_n;
  logic       we;
  logic [3:0] write_addr;
  logic       pixel;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       blank;
  logic       frame_start;

  int   checks   = 0;
  int   failures = 0;
  logic fb_m [0:FBN-1];

  always #20 clk_25 = ~clk_25;

  qqvga_scanout #(
    .ADDR_WIDTH(4), .H_RES(4), .V_RES(3), .COLOR_BITS(4),
    .H_FP(4), .H_SYNC(8), .H_BP(4), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk_25(clk_25),
    .reset_n(reset_n),
    .we(we),
    .write_addr(write_addr),
    .pixel(pixel),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .blank(blank),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input int h, input int v,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s h=%0d v=%0d observed=%0h expected=%0h", tag, h, v, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_25);
  endtask

  task automatic wr(input int a, input logic val);
    we         = 1'b1;
    write_addr = 4'(a);
    pixel      = val;
    @(negedge clk_25);
    we         = 1'b0;
    if (a < FBN) fb_m[a] = val;
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start !== 1'b1 && n < 1000) begin
      @(negedge clk_25);
      n++;
    end
    check("wait_fs", 0, 0, 32'(frame_start), 32'd1);
  endtask

  // Starts on a frame_start cycle; compares every output of one frame against the screen model.
  task automatic check_frame();
    for (int t = 0; t < FRAME; t++) begin
      int   h;
      int   v;
      logic eb;
      logic ep;
      h  = t % HT;
      v  = t / HT;
      eb = !(h < HV && v < VV);
      ep = !eb && fb_m[(v / 4) * 4 + h / 4];
      check("blank", h, v, 32'(blank), 32'(eb));
      check("hsync", h, v, 32'(vga_hsync), 32'(!(h >= HS0 && h < HS1)));
      check("vsync", h, v, 32'(vga_vsync), 32'(!(v >= VS0 && v < VS1)));
      check("frame_start", h, v, 32'(frame_start), 32'(t == 0));
      check("rgb", h, v, 32'({vga_r, vga_g, vga_b}), ep ? 32'hFFF : 32'h0);
      @(negedge clk_25);
    end
    check("fs_period", 0, 0, 32'(frame_start), 32'd1);
  endtask

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    we         = 1'b0;
    write_addr = '0;
    pixel      = 1'b0;
    @(negedge clk_25);
    for (int a = 0; a < 16; a++) wr(a, 1'b0);

    // T1: reset values, then first frame_start after two edges
    check("rst_hsync", 0, 0, 32'(vga_hsync), 32'd1);
    check("rst_vsync", 0, 0, 32'(vga_vsync), 32'd1);
    check("rst_rgb", 0, 0, 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("rst_blank", 0, 0, 32'(blank), 32'd1);
    check("rst_fs", 0, 0, 32'(frame_start), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_25);
    check("fs_edge1", 0, 0, 32'(frame_start), 32'd0);
    @(negedge clk_25);
    check("fs_edge2", 0, 0, 32'(frame_start), 32'd1);

    // T2/T3: full timing of a blank framebuffer
    check_frame();

    // T4: two scaled blocks
    wr(0, 1'b1);
    wr(5, 1'b1);
    wait_fs();
    check_frame();

    // T5: last address, out-of-range write, then all ones
    wr(11, 1'b1);
    wr(12, 1'b1);
    wait_fs();
    check_frame();
    for (int a = 0; a < FBN; a++) wr(a, 1'b1);
    wait_fs();
    check_frame();

    // T6a: write addr 0 on the same edge that reads it for pixel (0,0)
    step(FRAME - 2);
    we         = 1'b1;
    write_addr = 4'd0;
    pixel      = 1'b0;
    @(negedge clk_25);
    we         = 1'b0;
    fb_m[0]    = 1'b0;
    @(negedge clk_25);
    check("coll_fs", 0, 0, 32'(frame_start), 32'd1);
    check("coll_old", 0, 0, 32'({vga_r, vga_g, vga_b}), 32'hFFF);
    @(negedge clk_25);
    check("coll_new", 1, 0, 32'({vga_r, vga_g, vga_b}), 32'h0);
    step(FRAME - 1);
    check_frame();

    // T6b: asynchronous reset mid-line, scan restarts, framebuffer retained
    step(5);
    check("pre_rst_rgb", 5, 0, 32'({vga_r, vga_g, vga_b}), 32'hFFF);
    check("pre_rst_blank", 5, 0, 32'(blank), 32'd0);
    reset_n = 1'b0;
    #1;
    check("arst_hsync", 0, 0, 32'(vga_hsync), 32'd1);
    check("arst_vsync", 0, 0, 32'(vga_vsync), 32'd1);
    check("arst_rgb", 0, 0, 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("arst_blank", 0, 0, 32'(blank), 32'd1);
    check("arst_fs", 0, 0, 32'(frame_start), 32'd0);
    step(3);
    reset_n = 1'b1;
    @(negedge clk_25);
    check("rel_edge1", 0, 0, 32'(frame_start), 32'd0);
    @(negedge clk_25);
    check("rel_edge2", 0, 0, 32'(frame_start), 32'd1);
    check_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
